// File: rtl/slow_tick_debouncer_pkg.sv
// Shared definitions for the slow-tick sensor debouncer: FSM state encoding
// and the default stability requirement.
package slow_tick_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        HIGH   = 2'd2,
        DISARM = 2'd3
    } state_t;

    localparam int DEFAULT_STABLE_SAMPLES = 4;

    // The debounced level is a pure function of the state.
    function automatic logic state_level(input state_t s);
        return (s == HIGH) || (s == DISARM);
    endfunction

endpackage

// File: rtl/slow_tick_debouncer_if.sv
// Signal bundle between the divided-clock/sensor side and the debouncer.
interface slow_tick_debouncer_if;

    logic slow_clk;
    logic sensor_raw;
    logic tick;
    logic level;
    logic rise_pulse;
    logic fall_pulse;

    modport master (
        output slow_clk,
        output sensor_raw,
        input  tick,
        input  level,
        input  rise_pulse,
        input  fall_pulse
    );

    modport slave (
        input  slow_clk,
        input  sensor_raw,
        output tick,
        output level,
        output rise_pulse,
        output fall_pulse
    );

endinterface

// File: rtl/slow_tick_debouncer_sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous single-bit line into clk.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // NOTE: non-blocking assignments so both stages shift on the same edge;
    // blocking here would collapse the chain into a single flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/slow_tick_debouncer.sv
// Turns the divided slow_clk into one-cycle sampling strobes and debounces
// the customer sensor on those strobes, producing a clean level and pulses.
module slow_tick_debouncer
    import slow_tick_debouncer_pkg::*;
#(
    parameter int STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES
) (
    input  logic                 clk,
    input  logic                 rst,
    slow_tick_debouncer_if.slave bus
);

    localparam int                CNT_W    = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

    logic             s2;
    logic             samp;
    logic             s3_q,    s3_d;
    logic             tick;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;

    sync_2ff u_slow_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.slow_clk),
        .q   (s2)
    );

    sync_2ff u_sensor_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.sensor_raw),
        .q   (samp)
    );

    // Third slow_clk stage exists only to detect the synchronized rising edge.
    assign s3_d = s2;
    assign tick = s2 & ~s3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_q    <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s3_q    <= s3_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (samp) begin
                        state_d = ARM;
                        cnt_d   = CNT_ONE;
                    end
                end
                ARM: begin
                    if (!samp) begin
                        state_d = IDLE;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = HIGH;
                        cnt_d   = CNT_ZERO;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!samp) begin
                        state_d = DISARM;
                        cnt_d   = CNT_ONE;
                    end
                end
                DISARM: begin
                    if (samp) begin
                        state_d = HIGH;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = CNT_ZERO;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign bus.tick       = tick;
    assign bus.level      = state_level(state_q);
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;

endmodule

// File: tb/tb_slow_tick_debouncer.sv
// Scoreboard bench: stimulus pushes the expected outcome of every slow_clk
// rise; a monitor pops it when the DUT ticks and checks level and pulses.
module tb_slow_tick_debouncer;

    localparam int S = 4;

    typedef struct {
        int cyc;
        bit lvl;
        bit rise;
        bit fall;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    exp_t sb_q[$];
    exp_t cur;
    bit   pending   = 1'b0;
    bit   exp_level = 1'b0;

    // Reference model: level plus length of the current disagreeing run.
    bit m_level = 1'b0;
    int m_run   = 0;

    slow_tick_debouncer_if bus_if ();

    slow_tick_debouncer #(.STABLE_SAMPLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Consume one sample at the level of "S agreeing samples flip the level".
    task automatic model_sample(input bit s, output bit rise, output bit fall);
        rise = 1'b0;
        fall = 1'b0;
        if (s != m_level) begin
            m_run++;
            if (m_run == S) begin
                m_level = s;
                rise    = s;
                fall    = !s;
                m_run   = 0;
            end
        end else begin
            m_run = 0;
        end
    endtask

    // One slow_clk period, entered and left with slow_clk low at posedge+1.
    // The sensor may bounce early in the low phase, then settles to val at
    // least 3 cycles before the rise and holds through the high phase.
    task automatic do_period(input bit val, input int bounce, input int hi, input int lo);
        exp_t e;
        bit   r;
        bit   f;
        for (int i = 0; i < lo; i++) begin
            if (i < bounce) bus_if.sensor_raw = ~bus_if.sensor_raw;
            else            bus_if.sensor_raw = val;
            @(posedge clk); #1;
        end
        bus_if.slow_clk = 1'b1;
        model_sample(val, r, f);
        e.cyc  = cyc + 2;
        e.lvl  = m_level;
        e.rise = r;
        e.fall = f;
        sb_q.push_back(e);
        repeat (hi) begin
            @(posedge clk); #1;
        end
        bus_if.slow_clk = 1'b0;
    endtask

    task automatic apply_reset(input string tag);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check({tag, "_level"}, bus_if.level,      0);
        check({tag, "_rise"},  bus_if.rise_pulse, 0);
        check({tag, "_fall"},  bus_if.fall_pulse, 0);
        check({tag, "_tick"},  bus_if.tick,       0);
        m_level = 1'b0;
        m_run   = 0;
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Monitor: pops on every DUT tick, checks the outcome one cycle later,
    // and otherwise requires a steady level and quiet pulses.
    always @(negedge clk) begin
        if (rst) begin
            pending   = 1'b0;
            exp_level = 1'b0;
        end else if (pending) begin
            check("tick_width", bus_if.tick,       0);
            check("level",      bus_if.level,      cur.lvl);
            check("rise_pulse", bus_if.rise_pulse, cur.rise);
            check("fall_pulse", bus_if.fall_pulse, cur.fall);
            exp_level = cur.lvl;
            pending   = 1'b0;
        end else if (bus_if.tick) begin
            if (sb_q.size() == 0) begin
                check("tick_unexpected", bus_if.tick, 0);
            end else begin
                cur = sb_q.pop_front();
                check("tick_latency", cyc, cur.cyc);
                check("level_at_tick", bus_if.level, exp_level);
                pending = 1'b1;
            end
        end else begin
            check("level_hold", bus_if.level,      exp_level);
            check("rise_quiet", bus_if.rise_pulse, 0);
            check("fall_quiet", bus_if.fall_pulse, 0);
        end
    end

    initial begin
        bit prev;
        int lo;
        bus_if.slow_clk   = 1'b0;
        bus_if.sensor_raw = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_rel_level", bus_if.level,      0);
        check("rst_rel_rise",  bus_if.rise_pulse, 0);
        check("rst_rel_fall",  bus_if.fall_pulse, 0);
        check("rst_rel_tick",  bus_if.tick,       0);
        repeat (5) @(posedge clk);
        #1;

        // Steady high, 16-cycle period: rise on the 4th tick.
        repeat (4) do_period(1'b1, 0, 8, 8);
        // Steady low: fall on the 4th tick.
        repeat (4) do_period(1'b0, 0, 8, 8);
        // 1,1,1,0 aborts; then 1,1,1,1 rises.
        do_period(1'b1, 0, 8, 8);
        do_period(1'b1, 0, 8, 8);
        do_period(1'b1, 0, 8, 8);
        do_period(1'b0, 0, 8, 8);
        repeat (4) do_period(1'b1, 0, 8, 8);
        // From high: 0,1,0,0 gives no fall, two more zeros complete the run.
        do_period(1'b0, 0, 8, 8);
        do_period(1'b1, 0, 8, 8);
        do_period(1'b0, 0, 8, 8);
        do_period(1'b0, 0, 8, 8);
        do_period(1'b0, 0, 8, 8);
        do_period(1'b0, 0, 8, 8);
        // Fast bounce between two ticks that both sample 0.
        do_period(1'b0, 0, 4, 8);
        do_period(1'b0, 15, 4, 20);
        // Reset while in ARM with cnt=2, then four fresh highs are needed.
        do_period(1'b1, 0, 8, 8);
        do_period(1'b1, 0, 8, 8);
        apply_reset("rst_arm");
        repeat (4) do_period(1'b1, 0, 8, 8);
        // Reset while HIGH must drop the level immediately.
        apply_reset("rst_high");

        // Randomized runs with random bounce and slow_clk duty.
        prev = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) prev = ~prev;
            lo = int'($urandom_range(5, 12));
            do_period(prev, int'($urandom_range(0, lo - 3)),
                      int'($urandom_range(3, 8)), lo);
        end

        repeat (6) @(posedge clk);
        #1;
        check("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
